// File: rtl/ternary_hazard_unit.sv
// Stall/flush controller for the ternary pipeline, sitting in ID beside the EX forwarding logic.
// Latency: stall/flush controls are combinational (0 cycles); MC tracking and stall counter are registered.
// Backpressure: any unresolved hazard holds PC and IF/ID and bubbles ID/EX; a taken branch flushes instead.
//
// Ports:
//   clk, rst_n                      - pipeline clock, async active-low reset
//   id_*                            - instruction currently in ID (sources, dest, kind)
//   ex_rd, ex_mem_read              - EX destination and load flag (load-use detection)
//   ex_branch_taken                 - taken branch in EX; flush has priority over stalls
//   stall_if/stall_id/bubble_ex/flush_id - pipeline controls
//   mc_busy, mc_done, mc_rd         - outstanding multi-cycle (MUL/DIV) op tracking
//   stall_cycles                    - saturating count of cycles with stall_id=1

package ternary_pkg;
  // Balanced-ternary digit; 2'b11 is unused.
  typedef logic [1:0] trit_t;
  localparam trit_t T_ZERO = 2'b00;
  localparam trit_t T_POS  = 2'b01;
  localparam trit_t T_NEG  = 2'b10;
endpackage

module ternary_hazard_unit
  import ternary_pkg::*;
#(
  parameter int MC_LATENCY  = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  trit_t [2:0]            id_rs1,
  input  trit_t [2:0]            id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  trit_t [2:0]            id_rd,
  input  logic                   id_reg_write,
  input  logic                   id_is_mc,
  input  trit_t [2:0]            ex_rd,
  input  logic                   ex_mem_read,
  input  logic                   ex_branch_taken,
  output logic                   stall_if,
  output logic                   stall_id,
  output logic                   bubble_ex,
  output logic                   flush_id,
  output logic                   mc_busy,
  output logic                   mc_done,
  output trit_t [2:0]            mc_rd,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam trit_t [2:0] R0 = {T_ZERO, T_ZERO, T_ZERO};
  localparam logic [3:0]  MC_LAT4 = 4'(MC_LATENCY);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_MC_BUSY = 1'b1
  } state_e;

  state_e      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  trit_t [2:0] r_mc_rd, w_mc_rd_nxt;
  logic [STALL_CNT_W-1:0] r_stall_cycles;

  logic w_busy;
  logic w_load_use, w_mc_raw, w_mc_waw, w_mc_struct, w_hazard;
  logic w_issue;

  assign w_busy = (r_state == S_MC_BUSY);

  // Hazard terms. R0 is hard-wired zero, so a match against it is never a hazard.
  assign w_load_use = id_valid && ex_mem_read && (ex_rd != R0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

  assign w_mc_raw = id_valid && w_busy && (r_mc_rd != R0) &&
                    ((id_uses_rs1 && (id_rs1 == r_mc_rd)) ||
                     (id_uses_rs2 && (id_rs2 == r_mc_rd)));

  assign w_mc_waw = id_valid && w_busy && id_reg_write &&
                    (r_mc_rd != R0) && (id_rd == r_mc_rd);

  assign w_mc_struct = id_valid && w_busy && id_is_mc;

  assign w_hazard = w_load_use | w_mc_raw | w_mc_waw | w_mc_struct;

  // Flush wins over stall: the ID instruction is being killed anyway.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    if (ex_branch_taken) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
    end else if (w_hazard) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
    end
  end

  // mc_struct already blocks an issue while busy, so issue implies IDLE.
  assign w_issue = id_valid && id_is_mc && !w_hazard && !ex_branch_taken;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mc_rd_nxt = r_mc_rd;
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          w_state_nxt = S_MC_BUSY;
          w_cnt_nxt   = MC_LAT4;
          w_mc_rd_nxt = id_reg_write ? id_rd : R0;
        end
      end
      S_MC_BUSY: begin
        // A taken branch does not cancel the op: it is older than the branch.
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_mc_rd <= R0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mc_rd <= w_mc_rd_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (stall_id && (r_stall_cycles != {STALL_CNT_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
    end
  end

  assign mc_busy      = w_busy;
  assign mc_done      = w_busy && (r_cnt == 4'd1);
  assign mc_rd        = r_mc_rd;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_ternary_hazard_unit.sv
module tb_ternary_hazard_unit;
  import ternary_pkg::*;

  localparam int L  = 4;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_is_mc;
  trit_t [2:0] id_rs1, id_rs2, id_rd, ex_rd;
  logic        ex_mem_read, ex_branch_taken;
  logic        stall_if, stall_id, bubble_ex, flush_id, mc_busy, mc_done;
  trit_t [2:0] mc_rd;
  logic [CW-1:0] stall_cycles;

  ternary_hazard_unit #(.MC_LATENCY(L), .STALL_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_mc(id_is_mc), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex), .flush_id(flush_id),
    .mc_busy(mc_busy), .mc_done(mc_done), .mc_rd(mc_rd), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the MC op is described by its issue cycle; the counter by an integer.
  longint      cyc = 0;
  bit          m_active = 1'b0;
  longint      m_issue = 0;
  trit_t [2:0] m_rd;
  int          m_stalls = 0;

  trit_t [2:0] A_R0, A_X, A_Y, A_Z;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_busy();
    return m_active && (cyc - m_issue) >= 1 && (cyc - m_issue) <= L;
  endfunction

  function automatic bit reads(input trit_t [2:0] a);
    return (a != A_R0) && ((id_uses_rs1 && id_rs1 == a) || (id_uses_rs2 && id_rs2 == a));
  endfunction

  function automatic bit m_hazard();
    bit lu, dep;
    if (!id_valid) return 1'b0;
    lu  = ex_mem_read && reads(ex_rd);
    dep = m_busy() && (reads(m_rd) || id_is_mc ||
                       (id_reg_write && m_rd != A_R0 && id_rd == m_rd));
    return lu || dep;
  endfunction

  task automatic idle_inputs();
    id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_reg_write = 0; id_is_mc = 0;
    id_rs1 = A_R0; id_rs2 = A_R0; id_rd = A_R0; ex_rd = A_R0;
    ex_mem_read = 0; ex_branch_taken = 0;
  endtask

  // One clock: check every output against the model mid-cycle, then advance the model.
  task automatic step(input string tag);
    bit hz, e_stall, e_flush, e_busy, e_done;
    @(negedge clk);
    hz      = m_hazard();
    e_flush = ex_branch_taken;
    e_stall = !e_flush && hz;
    e_busy  = m_busy();
    e_done  = m_active && (cyc - m_issue) == L;
    chk({tag, ".stall_if"},  32'(stall_if),  32'(e_stall));
    chk({tag, ".stall_id"},  32'(stall_id),  32'(e_stall));
    chk({tag, ".bubble_ex"}, 32'(bubble_ex), 32'(e_stall || e_flush));
    chk({tag, ".flush_id"},  32'(flush_id),  32'(e_flush));
    chk({tag, ".mc_busy"},   32'(mc_busy),   32'(e_busy));
    chk({tag, ".mc_done"},   32'(mc_done),   32'(e_done));
    chk({tag, ".stall_cyc"}, 32'(stall_cycles), 32'(m_stalls));
    if (e_busy) chk({tag, ".mc_rd"}, 32'(mc_rd), 32'(m_rd));
    @(posedge clk);
    if (e_stall && m_stalls < SAT) m_stalls++;
    if (id_valid && id_is_mc && !hz && !e_flush) begin
      m_active = 1'b1;
      m_issue  = cyc;
      m_rd     = id_reg_write ? id_rd : A_R0;
    end
    cyc++;
    #1;
  endtask

  function automatic trit_t [2:0] rand_addr();
    case ($urandom_range(0, 4))
      0: return A_R0;
      1: return A_X;
      2: return A_Y;
      3: return A_Z;
      default: return {trit_t'($urandom_range(0, 2)), trit_t'($urandom_range(0, 2)),
                       trit_t'($urandom_range(0, 2))};
    endcase
  endfunction

  initial begin
    A_R0 = {T_ZERO, T_ZERO, T_ZERO};
    A_X  = {T_POS, T_ZERO, T_NEG};
    A_Y  = {T_ZERO, T_POS, T_POS};
    A_Z  = {T_NEG, T_NEG, T_POS};
    m_rd = A_R0;
    idle_inputs();
    rst_n = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst.stall_id", 32'(stall_id), 32'd0);
    chk("rst.mc_busy", 32'(mc_busy), 32'd0);
    chk("rst.mc_rd", 32'(mc_rd), 32'd0);
    chk("rst.stall_cyc", 32'(stall_cycles), 32'd0);
    @(posedge clk); cyc++; #1;
    rst_n = 1'b1;
    step("idle");

    // 1. Load-use on rs2: one stall, then the bubble clears ex_mem_read.
    id_valid = 1; ex_mem_read = 1; ex_rd = A_X; id_rs2 = A_X; id_uses_rs2 = 1;
    step("lu.stall");
    chk("lu.cnt_after", 32'(stall_cycles), 32'd1);
    ex_mem_read = 0;
    step("lu.release");
    ex_mem_read = 1; id_uses_rs2 = 0;
    step("lu.unused_src");
    id_uses_rs2 = 1; ex_rd = A_R0; id_rs2 = A_R0;
    step("lu.r0");
    idle_inputs();

    // 2. MC issue in cycle 0, dependent reader held in ID cycles 1..5.
    id_valid = 1; id_is_mc = 1; id_reg_write = 1; id_rd = A_Y;
    step("mc.issue");
    idle_inputs();
    id_valid = 1; id_uses_rs1 = 1; id_rs1 = A_Y;
    for (int i = 1; i <= L + 1; i++) step($sformatf("mc.dep%0d", i));
    idle_inputs();
    step("mc.gap");

    // 3. Structural, WAW, and an unrelated ALU op against an MC op issued in cycle 0.
    id_valid = 1; id_is_mc = 1; id_reg_write = 1; id_rd = A_Z;
    step("st.issue");
    idle_inputs(); id_valid = 1; id_rs1 = A_X; id_uses_rs1 = 1;
    step("st.unrelated");
    id_is_mc = 1; id_rd = A_Y; id_reg_write = 1;
    for (int i = 2; i <= L + 1; i++) step($sformatf("st.mc%0d", i));
    idle_inputs();
    for (int i = 0; i <= L; i++) step($sformatf("st.drain%0d", i));
    id_valid = 1; id_is_mc = 1; id_reg_write = 1; id_rd = A_X;
    step("waw.issue");
    idle_inputs(); id_valid = 1; id_reg_write = 1; id_rd = A_X;
    for (int i = 1; i <= L + 1; i++) step($sformatf("waw.alu%0d", i));
    idle_inputs();

    // 4. Branch flush beats a load-use stall and blocks an MC issue.
    id_valid = 1; ex_mem_read = 1; ex_rd = A_X; id_rs1 = A_X; id_uses_rs1 = 1;
    id_is_mc = 1; id_reg_write = 1; id_rd = A_Z; ex_branch_taken = 1;
    step("fl.prio");
    idle_inputs();
    step("fl.no_issue");

    // 6. Saturation: 20 consecutive load-use stalls.
    id_valid = 1; ex_mem_read = 1; ex_rd = A_Z; id_rs2 = A_Z; id_uses_rs2 = 1;
    for (int i = 0; i < 20; i++) step($sformatf("sat%0d", i));
    chk("sat.final", 32'(stall_cycles), 32'(SAT));
    idle_inputs();

    // 5. Reset in cycle 2 of an MC op: immediate clear, no mc_done afterwards.
    id_valid = 1; id_is_mc = 1; id_reg_write = 1; id_rd = A_Y;
    step("rm.issue");
    idle_inputs(); id_valid = 1; id_is_mc = 1;
    step("rm.c1");
    rst_n = 1'b0;
    #1;
    chk("rm.stall_id", 32'(stall_id), 32'd0);
    chk("rm.bubble_ex", 32'(bubble_ex), 32'd0);
    chk("rm.mc_busy", 32'(mc_busy), 32'd0);
    chk("rm.mc_rd", 32'(mc_rd), 32'd0);
    chk("rm.stall_cyc", 32'(stall_cycles), 32'd0);
    m_active = 1'b0; m_stalls = 0;
    idle_inputs();
    @(posedge clk); cyc++; #1;
    rst_n = 1'b1;
    for (int i = 0; i < L + 2; i++) step($sformatf("rm.after%0d", i));

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      id_valid        = ($urandom_range(0, 7) != 0);
      id_rs1          = rand_addr();
      id_rs2          = rand_addr();
      id_rd           = rand_addr();
      ex_rd           = rand_addr();
      id_uses_rs1     = 1'($urandom_range(0, 1));
      id_uses_rs2     = 1'($urandom_range(0, 1));
      id_reg_write    = 1'($urandom_range(0, 1));
      id_is_mc        = ($urandom_range(0, 2) == 0);
      ex_mem_read     = ($urandom_range(0, 3) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
